// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: random start delay, jump-start detect and reaction timing.
// Define F1_BCD_OUT_EN to count and report the reaction time as 4-digit BCD.
module f1_reaction_timer #(
    parameter int TICK_DIV     = 1000,
    parameter int MIN_DELAY_MS = 200,
    parameter int LFSR_W       = 7,
    parameter int RT_MAX       = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_delay,
    input  logic        btn,
    output logic        lights_out,
    output logic        busy,
    output logic        react_valid,
    output logic [15:0] react_ms,
    output logic        jump_start
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [15:0] MIN_D = 16'(MIN_DELAY_MS);

`ifdef F1_BCD_OUT_EN
    localparam int CNT_W = 16;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Digit-wise ripple: a 9 rolls to 0 and carries into the next digit.
    function automatic logic [15:0] cnt_inc(input logic [15:0] c);
        logic [15:0] r;
        logic cy;
        r  = c;
        cy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cy) begin
                if (c[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = c[i*4 +: 4] + 4'd1;
                    cy = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [CNT_W-1:0] CNT_MAX = to_bcd(RT_MAX);
`else
    localparam int CNT_W = 14;

    function automatic logic [13:0] cnt_inc(input logic [13:0] c);
        return c + 14'd1;
    endfunction

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RT_MAX);
`endif

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        TIMING,
        DONE
    } state_t;

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [DIV_W-1:0]  div;
    logic [15:0]       delay_cnt;
    logic [CNT_W-1:0]  react_cnt;
    logic              cmd_delay_q;

    logic        tick;
    logic        arm;
    logic        expire;
    logic [15:0] cnt_ext;

    assign tick   = (div == DIV_LAST);
    assign arm    = cmd_delay & ~cmd_delay_q;
    assign expire = (state == DELAY) && tick && (delay_cnt == 16'd1);

`ifdef F1_BCD_OUT_EN
    assign cnt_ext = react_cnt;
`else
    assign cnt_ext = {2'b00, react_cnt};
`endif

    // A press in the expiry cycle is a jump start, so it masks the pulse.
    assign lights_out = expire && !btn && !rst;
    assign busy       = (state == DELAY) || (state == TIMING);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lfsr        <= LFSR_W'(1);
            div         <= '0;
            delay_cnt   <= '0;
            react_cnt   <= '0;
            cmd_delay_q <= 1'b0;
            react_valid <= 1'b0;
            react_ms    <= '0;
            jump_start  <= 1'b0;
        end else begin
            cmd_delay_q <= cmd_delay;
            lfsr        <= {lfsr[LFSR_W-2:0],
                            lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2]};
            react_valid <= 1'b0;
            div         <= tick ? '0 : div + 1'b1;

            unique case (state)
                IDLE: begin
                    if (arm) begin
                        delay_cnt  <= MIN_D + 16'(lfsr);
                        jump_start <= 1'b0;
                        div        <= '0;
                        state      <= DELAY;
                    end
                end
                DELAY: begin
                    if (btn) begin
                        jump_start  <= 1'b1;
                        react_ms    <= '0;
                        react_valid <= 1'b1;
                        state       <= DONE;
                    end else if (tick) begin
                        delay_cnt <= delay_cnt - 16'd1;
                        if (delay_cnt == 16'd1) begin
                            react_cnt <= '0;
                            state     <= TIMING;
                        end
                    end
                end
                TIMING: begin
                    if (btn) begin
                        react_ms    <= cnt_ext;
                        react_valid <= 1'b1;
                        state       <= DONE;
                    end else if (tick && react_cnt != CNT_MAX) begin
                        react_cnt <= cnt_inc(react_cnt);
                    end
                end
                DONE: begin
                    if (!btn) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Bench for f1_reaction_timer: random arm/press timing against a cycle-count model.
// Build with F1_BCD_OUT_EN defined to check the BCD variant.
module tb_f1_reaction_timer;

    localparam int TD     = 4;
    localparam int MIN_MS = 2;
    localparam int RTM    = 9999;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_delay;
    logic        btn;
    logic        lights_out;
    logic        busy;
    logic        react_valid;
    logic [15:0] react_ms;
    logic        jump_start;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int r0     = 0;

    int          lo_cnt = 0;
    int          lo_cyc = -1;
    int          rv_cnt = 0;
    int          rv_cyc = -1;
    logic [15:0] rv_ms  = '0;

    always #5 clk = ~clk;

    f1_reaction_timer #(
        .TICK_DIV    (TD),
        .MIN_DELAY_MS(MIN_MS),
        .LFSR_W      (7),
        .RT_MAX      (RTM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_delay  (cmd_delay),
        .btn        (btn),
        .lights_out (lights_out),
        .busy       (busy),
        .react_valid(react_valid),
        .react_ms   (react_ms),
        .jump_start (jump_start)
    );

    // Pulse recorder, sampled mid-cycle
    always @(negedge clk) begin
        if (lights_out === 1'b1) begin
            lo_cnt++;
            lo_cyc = cyc;
        end
        if (react_valid === 1'b1) begin
            rv_cnt++;
            rv_cyc = cyc;
            rv_ms  = react_ms;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // LFSR value n cycles after reset release, from x^7+x^6+1 starting at 1
    function automatic int lfsr_at(input int n);
        logic [6:0] s;
        s = 7'd1;
        for (int i = 0; i < n; i++) s = {s[5:0], s[6] ^ s[5]};
        return int'(s);
    endfunction

    function automatic logic [15:0] enc(input int v);
`ifdef F1_BCD_OUT_EN
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`else
        return 16'(v);
`endif
    endfunction

    // Arm now; press at arm+press_abs, or at lights+press_rel when use_rel.
    task automatic trial(input string tag, input int press_abs,
                         input int press_rel, input bit use_rel,
                         input int hold, input bit reedge);
        int a, l, lc, p, lo0, rv0, exp_ms, end_c;
        bit jump;
        lo0       = lo_cnt;
        rv0       = rv_cnt;
        a         = cyc;
        l         = lfsr_at(a - r0);
        lc        = a + (MIN_MS + l) * TD;
        p         = use_rel ? lc + press_rel : a + press_abs;
        jump      = (p <= lc);
        exp_ms    = jump ? 0 : (p - lc - 1) / TD;
        if (exp_ms > RTM) exp_ms = RTM;
        end_c     = (p + 3 > a + hold) ? p + 3 : a + hold;
        cmd_delay = 1'b1;
        btn       = (cyc >= p);
        while (cyc < end_c) begin
            step();
            cmd_delay = (cyc < a + hold);
            btn       = (cyc >= p);
            if (cyc == a + 1) begin
                chk({tag, "_busy_arm"}, 32'(busy), 32'd1);
                chk({tag, "_js_clr"}, 32'(jump_start), 32'd0);
            end
        end
        chk({tag, "_rv_cnt"}, rv_cnt - rv0, 1);
        chk({tag, "_rv_cyc"}, rv_cyc, p + 1);
        chk({tag, "_rv_ms"}, 32'(rv_ms), 32'(enc(exp_ms)));
        chk({tag, "_react_ms"}, 32'(react_ms), 32'(enc(exp_ms)));
        chk({tag, "_jump"}, 32'(jump_start), 32'(jump));
        chk({tag, "_lo_cnt"}, lo_cnt - lo0, jump ? 0 : 1);
        if (!jump) chk({tag, "_lo_cyc"}, lo_cyc, lc);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        if (reedge) begin
            cmd_delay = 1'b1;
            step();
            step();
            step();
            chk({tag, "_reedge_busy"}, 32'(busy), 32'd0);
        end
        btn = 1'b0;
        step();
        step();
        step();
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_one_result"}, rv_cnt - rv0, 1);
        cmd_delay = 1'b0;
        step();
        step();
    endtask

    task automatic rst_mid(input string tag, input bit in_timing);
        int a, l, lc, at, lo0, rv0;
        a         = cyc;
        l         = lfsr_at(a - r0);
        lc        = a + (MIN_MS + l) * TD;
        at        = in_timing ? lc + 6 : a + 5;
        cmd_delay = 1'b1;
        while (cyc < at) begin
            step();
            cmd_delay = (cyc < a + 2);
        end
        chk({tag, "_busy_pre"}, 32'(busy), 32'd1);
        lo0 = lo_cnt;
        rv0 = rv_cnt;
        rst = 1'b1;
        step();
        chk({tag, "_lo"}, 32'(lights_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rv"}, 32'(react_valid), 32'd0);
        chk({tag, "_ms"}, 32'(react_ms), 32'd0);
        chk({tag, "_js"}, 32'(jump_start), 32'd0);
        rst = 1'b0;
        r0  = cyc;
        repeat (600) step();
        chk({tag, "_no_lo"}, lo_cnt - lo0, 0);
        chk({tag, "_no_rv"}, rv_cnt - rv0, 0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_delay = 1'b0;
        btn       = 1'b0;
        step();
        step();
        rst = 1'b0;
        r0  = cyc;
        chk("rst_lo", 32'(lights_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rv", 32'(react_valid), 32'd0);
        chk("rst_ms", 32'(react_ms), 32'd0);
        chk("rst_js", 32'(jump_start), 32'd0);

        // Arm in the first cycle (lfsr=1): lights at +12, press 5 ticks later
        trial("first", 0, 21, 1'b1, 2, 1'b0);
        trial("jump3", 3, 0, 1'b0, 2, 1'b0);
        trial("after_jump", 0, 9, 1'b1, 2, 1'b0);
        trial("hold50", 3, 0, 1'b0, 50, 1'b1);
        trial("same_cyc", 0, 0, 1'b1, 1, 1'b0);
        trial("first_timing", 0, 1, 1'b1, 1, 1'b0);
        trial("tick_edge", 0, 4, 1'b1, 3, 1'b0);
        trial("tick_edge1", 0, 5, 1'b1, 3, 1'b0);

        for (int i = 0; i < 10; i++) begin
            int rel;
            repeat ($urandom_range(0, 7)) step();
            rel = int'($urandom_range(0, 90)) - 30;
            trial("rand", 0, rel, 1'b1, int'($urandom_range(1, 20)), 1'b0);
        end

        trial("sat", 0, TD * 10005 + 1, 1'b1, 2, 1'b0);

        rst_mid("rst_delay", 1'b0);
        rst_mid("rst_timing", 1'b1);
        trial("recover", 0, 13, 1'b1, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
